// File: rtl/timer_arbiter.sv
// Round-robin owner of a single shift-register width timer: grants one requester,
// pulses timer_start, waits for timer_finish (or a watchdog) and signals done.
module timer_arbiter #(
  parameter int unsigned ID_W       = 2,
  parameter int unsigned CHAR_WIDTH = 20,
  parameter int unsigned TIMEOUT    = 64,
  localparam int unsigned NUM_REQ   = 2 ** ID_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic [NUM_REQ-1:0] done,
  output logic               busy,
  output logic               timeout_err,
  output logic               timer_start,
  input  logic               timer_finish
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  if (TIMEOUT <= CHAR_WIDTH) begin : g_bad_timeout
    $error("timer_arbiter: TIMEOUT must exceed CHAR_WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [ID_W-1:0]    r_last;
  logic [CNT_W-1:0]   r_cnt;
  logic [NUM_REQ-1:0] r_grant;
  logic [ID_W-1:0]    r_grant_id;
  logic [NUM_REQ-1:0] r_done;
  logic               r_busy;
  logic               r_timeout_err;
  logic               r_timer_start;

  logic               w_found;
  logic [ID_W-1:0]    w_win_id;
  logic [ID_W-1:0]    w_idx;
  logic [NUM_REQ-1:0] w_win_oh;

  // Search upward from last+1, wrapping; the owner that just finished is tried last.
  always_comb begin
    w_found  = 1'b0;
    w_win_id = r_last;
    w_idx    = r_last;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_idx = r_last + ID_W'(i);
      if (!w_found && req[w_idx]) begin
        w_found  = 1'b1;
        w_win_id = w_idx;
      end
    end
    w_win_oh = NUM_REQ'(1) << w_win_id;
  end

  // Slot sequencer; every output is a register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_last        <= ID_W'(NUM_REQ - 1);
      r_cnt         <= '0;
      r_grant       <= '0;
      r_grant_id    <= '0;
      r_done        <= '0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timer_start <= 1'b0;
    end else begin
      r_timer_start <= 1'b0;
      r_done        <= '0;
      r_timeout_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant       <= w_win_oh;
            r_grant_id    <= w_win_id;
            r_busy        <= 1'b1;
            r_timer_start <= 1'b1;
            r_state       <= S_START;
          end
        end
        S_START: begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_cnt != CNT_LAST) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          // A finish seen on the timeout cycle still counts as a clean finish.
          if (timer_finish || (r_cnt == CNT_LAST)) begin
            r_done        <= r_grant;
            r_timeout_err <= ~timer_finish;
            r_grant       <= '0;
            r_state       <= S_DONE;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_last  <= r_grant_id;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign done        = r_done;
  assign busy        = r_busy;
  assign timeout_err = r_timeout_err;
  assign timer_start = r_timer_start;

endmodule

// File: tb/tb_timer_arbiter.sv
// Bench for timer_arbiter: directed scenarios plus random traffic, all checked per
// cycle against a slot-timing reference model.
module tb_timer_arbiter;

  localparam int unsigned ID_W    = 2;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CW      = 20;
  localparam int unsigned TMO     = 64;

  logic                clock = 1'b0;
  logic                reset;
  logic [NUM_REQ-1:0]  req;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic [NUM_REQ-1:0]  done;
  logic                busy;
  logic                timeout_err;
  logic                timer_start;
  logic                timer_finish;

  logic [CW-1:0] tmr = '0;
  logic          tie0;
  logic          inject;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  timer_arbiter #(.ID_W(ID_W), .CHAR_WIDTH(CW), .TIMEOUT(TMO)) dut (
    .clock        (clock),
    .reset        (reset),
    .req          (req),
    .grant        (grant),
    .grant_id     (grant_id),
    .done         (done),
    .busy         (busy),
    .timeout_err  (timeout_err),
    .timer_start  (timer_start),
    .timer_finish (timer_finish)
  );

  always #5 clock = ~clock;

  // Timer: no reset, shifts continuously, start loads a 1 into bit 0.
  always @(posedge clock) tmr <= {tmr[CW-2:0], timer_start};
  assign timer_finish = (tmr[CW-1] & ~tie0) | inject;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a slot is described by its start offset k, its end offset and owner.
  bit m_active;
  int m_k, m_end, m_owner, m_last, m_gid;
  bit m_err;

  task automatic model_reset();
    m_active = 0; m_k = 0; m_end = 0; m_owner = 0; m_err = 0;
    m_last = NUM_REQ - 1; m_gid = 0;
  endtask

  task automatic model_step();
    bit found;
    int idx;
    if (reset) begin
      model_reset();
    end else if (!m_active) begin
      if (req != '0) begin
        found = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
          idx = (m_last + off) % NUM_REQ;
          if (!found && req[idx]) begin
            found = 1;
            m_owner = idx;
          end
        end
        m_active = 1; m_k = 1; m_end = 0; m_err = 0; m_gid = m_owner;
      end
    end else if (m_end != 0 && m_k == m_end) begin
      m_active = 0;
      m_last = m_owner;
    end else begin
      if (m_k >= 2 && m_end == 0) begin
        if (timer_finish) m_end = m_k + 1;
        else if (m_k == TMO + 1) begin
          m_end = m_k + 1;
          m_err = 1;
        end
      end
      m_k++;
    end
  endtask

  int dl_id[$];
  int dl_cyc[$];
  bit dl_err[$];
  int last_start_cyc = -1;

  task automatic compare_all();
    logic [NUM_REQ-1:0] oh, e_grant, e_done;
    bit at_end;
    oh      = NUM_REQ'(1) << m_owner;
    at_end  = m_active && m_end != 0 && m_k == m_end;
    e_grant = (m_active && !at_end) ? oh : '0;
    e_done  = at_end ? oh : '0;
    check_eq("grant", 32'(grant), 32'(e_grant));
    check_eq("grant_id", 32'(grant_id), 32'(m_gid));
    check_eq("done", 32'(done), 32'(e_done));
    check_eq("busy", 32'(busy), 32'(m_active));
    check_eq("timeout_err", 32'(timeout_err), 32'(at_end && m_err));
    check_eq("timer_start", 32'(timer_start), 32'(m_active && m_k == 1));
    check_eq("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    if (timer_start) last_start_cyc = cyc;
    if (done != '0) begin
      for (int i = 0; i < NUM_REQ; i++) if (done[i]) dl_id.push_back(i);
      dl_cyc.push_back(cyc);
      dl_err.push_back(timeout_err);
    end
  endtask

  // Inputs set for the current cycle are consumed at the next rising edge.
  task automatic tick();
    #1;
    model_step();
    @(negedge clock);
    cyc++;
    compare_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    ticks(n);
    reset = 1'b0;
  endtask

  int t0, n0;

  initial begin
    reset = 1'b1; req = '0; tie0 = 1'b0; inject = 1'b0;
    model_reset();
    @(negedge clock);
    check_eq("rst_grant", 32'(grant), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    do_reset(25);

    // Single request
    req = 4'b0001; t0 = cyc;
    tick();
    check_eq("single_grant_c1", 32'(grant), 32'h1);
    check_eq("single_start_c1", 32'(last_start_cyc), 32'(t0 + 1));
    ticks(22);
    check_eq("single_busy_c23", 32'(busy), 32'd0);
    check_eq("single_done_cyc", 32'(dl_cyc[$]), 32'(t0 + 22));
    check_eq("single_done_id", 32'(dl_id[$]), 32'd0);
    check_eq("single_err", 32'(dl_err[$]), 32'd0);
    req = '0;
    ticks(5);

    // Round-robin with all requesters active
    do_reset(2);
    req = 4'b1111; t0 = cyc; n0 = dl_id.size();
    ticks(5 * 23);
    req = '0;
    ticks(30);
    check_eq("rr_first_cyc", 32'(dl_cyc[n0]), 32'(t0 + 22));
    for (int i = 0; i < 5; i++) begin
      check_eq("rr_order", 32'(dl_id[n0 + i]), 32'(i % NUM_REQ));
      if (i > 0) check_eq("rr_spacing", 32'(dl_cyc[n0 + i] - dl_cyc[n0 + i - 1]), 32'd23);
    end

    // Watchdog timeout
    tie0 = 1'b1; req = 4'b0100; t0 = cyc;
    tick();
    req = '0;
    ticks(66);
    check_eq("tmo_done_cyc", 32'(dl_cyc[$]), 32'(t0 + 66));
    check_eq("tmo_done_id", 32'(dl_id[$]), 32'd2);
    check_eq("tmo_err", 32'(dl_err[$]), 32'd1);
    check_eq("tmo_idle", 32'(busy), 32'd0);
    tie0 = 1'b0;
    ticks(25);

    // Stale finish in IDLE and START
    inject = 1'b1;
    tick();
    req = 4'b0001; t0 = cyc; n0 = dl_id.size();
    tick();
    req = '0;
    tick();
    inject = 1'b0;
    ticks(21);
    check_eq("stale_done_count", 32'(dl_id.size()), 32'(n0 + 1));
    check_eq("stale_done_cyc", 32'(dl_cyc[$]), 32'(t0 + 22));
    check_eq("stale_err", 32'(dl_err[$]), 32'd0);
    ticks(3);

    // Reset in the middle of WAIT
    req = 4'b0100; t0 = cyc; n0 = dl_id.size();
    tick();
    req = '0;
    ticks(9);
    reset = 1'b1;
    #1;
    check_eq("midrst_grant", 32'(grant), 32'd0);
    check_eq("midrst_busy", 32'(busy), 32'd0);
    check_eq("midrst_grant_id", 32'(grant_id), 32'd0);
    check_eq("midrst_start", 32'(timer_start), 32'd0);
    model_reset();
    ticks(15);
    check_eq("midrst_no_done", 32'(dl_id.size()), 32'(n0));
    reset = 1'b0; req = 4'b0101; t0 = cyc;
    tick();
    req = '0;
    ticks(22);
    check_eq("midrst_next_id", 32'(dl_id[$]), 32'd0);
    check_eq("midrst_next_cyc", 32'(dl_cyc[$]), 32'(t0 + 22));
    ticks(3);

    // Drop request mid-slot, then requeue behind req[3]
    req = 4'b0010; t0 = cyc; n0 = dl_id.size();
    ticks(5);
    req = '0;
    ticks(18);
    check_eq("drop_done_id", 32'(dl_id[$]), 32'd1);
    check_eq("drop_done_cyc", 32'(dl_cyc[$]), 32'(t0 + 22));
    req = 4'b1010;
    ticks(46);
    req = '0;
    ticks(5);
    check_eq("requeue_count", 32'(dl_id.size()), 32'(n0 + 3));
    check_eq("requeue_first", 32'(dl_id[n0 + 1]), 32'd3);
    check_eq("requeue_second", 32'(dl_id[n0 + 2]), 32'd1);

    // Random traffic with stray finishes, dead timer and occasional reset
    for (int i = 0; i < 1500; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      req    = NUM_REQ'($urandom);
      inject = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 99) == 0) tie0 = ~tie0;
      tick();
    end
    reset = 1'b0; req = '0; inject = 1'b0; tie0 = 1'b0;
    ticks(80);
    check_eq("final_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
